mdom_wvb_hdr_writer: RTL and testbench
======================================

MDOM_WVB_HDR_WRITER -- requirements
Module: mdom_wvb_hdr_writer

Interface
REQ-001 SHALL have ports clk (input, 1, sole clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 SHALL have the following event-start inputs:
- trig (in, 1): event-start strobe.
- trig_ltc (in, 49): local time count.
- trig_addr (in, 11): first sample address.
- trig_src_in (in, 2): trigger source.
- cnst_run_in (in, 1): constant-run flag.
REQ-003 SHALL have the following context inputs, sampled at trig:
- pre_conf_in (in, 5): pre-trigger sample count.
- sync_rdy_in (in, 1): LTC sync status.
- bsum_in (in, 19): baseline sum.
- bsum_len_sel_in (in, 3): baseline length select.
- bsum_valid_in (in, 1): baseline sum valid.
REQ-004 SHALL have the following event-end inputs:
- evt_done (in, 1): last-sample strobe.
- done_addr (in, 11): last sample address.
REQ-005 SHALL have the following header-FIFO ports:
- hdr_bundle (out, 103): packed header.
- hdr_wr (out, 1): write strobe.
- hdr_full (in, 1): FIFO full.
REQ-006 SHALL have the following status outputs:
- busy (out, 1): event in progress.
- ovfl (out, 1): sticky dropped-event flag.
- ovfl_clr (in, 1): clears ovfl.

Function
REQ-007 SHALL pack hdr_bundle with this bit layout:
- [48:0] ltc
- [59:49] start_addr
- [70:60] stop_addr
- [72:71] trig_src
- [73] cnst_run
- [78:74] pre_conf
- [79] sync_rdy
- [98:80] bsum
- [101:99] bsum_len_sel
- [102] bsum_valid
REQ-008 SHALL implement the states IDLE, ACQ and WRITE.
REQ-009 IDLE, trig=1: SHALL register all REQ-002/003 fields into the header register and go to ACQ on the next edge.
REQ-010 ACQ, evt_done=1: SHALL register done_addr as stop_addr and go to WRITE.
REQ-011 WRITE, hdr_full=0: SHALL assert hdr_wr for exactly one cycle and return to IDLE.
REQ-012 WRITE, hdr_full=1: SHALL hold in WRITE with hdr_wr=0 and the header unchanged.
REQ-013 hdr_bundle SHALL be registered and stable from entry to WRITE until hdr_wr has been asserted.
REQ-014 trig and evt_done in the same IDLE cycle: SHALL capture both, setting start_addr=trig_addr and stop_addr=done_addr, and go directly to WRITE (single-sample event).
REQ-015 trig outside IDLE: SHALL drop the event, leave the header untouched and set ovfl.
REQ-016 evt_done outside ACQ: SHALL be ignored, except as specified in REQ-014.
REQ-017 Minimum latency: SHALL assert hdr_wr 1 cycle after the evt_done edge when hdr_full=0.
REQ-018 Address wrap: SHALL pass stop_addr < start_addr unchanged; the module performs no address arithmetic.
REQ-019 busy SHALL be 1 whenever the state is not IDLE.
REQ-020 ovfl SHALL be cleared by ovfl_clr; if ovfl_clr and a drop occur in the same cycle, the set wins.

Reset
REQ-021 rst_n=0 SHALL asynchronously force the following:
- state to IDLE
- hdr_bundle to 0
- hdr_wr to 0
- busy to 0
- ovfl to 0
- drop counter (if present) to 0
REQ-022 Reset during ACQ or WRITE SHALL discard the partial header with no hdr_wr.
REQ-023 Release SHALL be synchronous to clk; the first trig SHALL be accepted on the first clk edge after rst_n rises.

Configuration
REQ-024 Macro MDOM_WVB_HDR_DROP_CNT_EN, when defined, SHALL add output drop_cnt (16 bits), with this behaviour:
- increments once per dropped trig;
- saturates at 0xFFFF;
- clears on ovfl_clr (same-cycle drop yields 1).
REQ-025 Without MDOM_WVB_HDR_DROP_CNT_EN, drop_cnt SHALL be absent and only ovfl SHALL report drops.

Verification
REQ-026 SHALL cover a basic event:
- stimulus: trig, trig_ltc=0x1_2345_6789_ABCD, trig_addr=0x010, trig_src_in=2, pre_conf_in=8, bsum_in=0x4_0000, bsum_valid_in=1; evt_done with done_addr=0x0FF 20 cycles later; hdr_full=0.
- response: one hdr_wr 1 cycle after evt_done, fields exactly as REQ-007.
REQ-027 SHALL cover backpressure:
- stimulus: hdr_full=1 for 50 cycles at WRITE.
- response: hdr_wr=0 and hdr_bundle stable throughout; single hdr_wr on the first cycle after hdr_full falls.
REQ-028 SHALL cover an overlapping trigger:
- stimulus: a second trig during ACQ.
- response: ovfl=1, drop_cnt=1 (macro on), and the first header written intact.
REQ-029 SHALL cover a same-cycle event:
- stimulus: trig and evt_done together, trig_addr=0x7FE, done_addr=0x7FE.
- response: header with start_addr=stop_addr=0x7FE.
REQ-030 SHALL cover reset mid-event:
- stimulus: rst_n pulsed low during WRITE while hdr_full=1.
- response: no hdr_wr, all outputs 0; the next full event is written normally.
REQ-031 SHALL cover wrap and saturation:
- stimulus: start_addr=0x7F0, stop_addr=0x00F; then 70000 drops.
- response: addresses unchanged in the header; drop_cnt=0xFFFF.

Source files
------------

// File: rtl/mdom_wvb_hdr_writer.sv
// ============================================================================
// Module   : mdom_wvb_hdr_writer
// Brief    : Captures waveform-buffer event context at trig, closes the event
//            on evt_done and writes one packed header into the header FIFO.
//            Optional: define MDOM_WVB_HDR_DROP_CNT_EN to add drop_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdom_wvb_hdr_writer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         trig,
  input  logic [48:0]  trig_ltc,
  input  logic [10:0]  trig_addr,
  input  logic [1:0]   trig_src_in,
  input  logic         cnst_run_in,
  input  logic [4:0]   pre_conf_in,
  input  logic         sync_rdy_in,
  input  logic [18:0]  bsum_in,
  input  logic [2:0]   bsum_len_sel_in,
  input  logic         bsum_valid_in,
  input  logic         evt_done,
  input  logic [10:0]  done_addr,
  output logic [102:0] hdr_bundle,
  output logic         hdr_wr,
  input  logic         hdr_full,
  output logic         busy,
  output logic         ovfl,
  input  logic         ovfl_clr
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
  ,
  output logic [15:0]  drop_cnt
`endif
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_acq   = 2'd1;
  localparam logic [1:0] c_st_write = 2'd2;

  logic [1:0]   r_state;
  logic [102:0] r_hdr;
  logic         r_ovfl;
  logic         w_drop;
  logic [10:0]  w_stop_at_trig;

  // Any trig that arrives while an event is still open is lost.
  assign w_drop = trig && (r_state != c_st_idle);

  // A same-cycle evt_done makes this a single-sample event.
  assign w_stop_at_trig = evt_done ? done_addr : r_hdr[70:60];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_hdr   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (trig) begin
            r_hdr <= {bsum_valid_in, bsum_len_sel_in, bsum_in, sync_rdy_in,
                      pre_conf_in, cnst_run_in, trig_src_in,
                      w_stop_at_trig, trig_addr, trig_ltc};
            r_state <= evt_done ? c_st_write : c_st_acq;
          end
        end
        c_st_acq: begin
          if (evt_done) begin
            r_hdr[70:60] <= done_addr;
            r_state      <= c_st_write;
          end
        end
        c_st_write: begin
          if (!hdr_full) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovfl <= 1'b0;
    end else if (w_drop) begin
      r_ovfl <= 1'b1;
    end else if (ovfl_clr) begin
      r_ovfl <= 1'b0;
    end
  end

`ifdef MDOM_WVB_HDR_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (ovfl_clr) begin
      r_drop_cnt <= {15'd0, w_drop};
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  // Write strobe follows hdr_full directly so the FIFO sees it the same cycle.
  assign hdr_wr     = (r_state == c_st_write) && !hdr_full;
  assign hdr_bundle = r_hdr;
  assign busy       = (r_state != c_st_idle);
  assign ovfl       = r_ovfl;

endmodule

`default_nettype wire

// File: tb/tb_mdom_wvb_hdr_writer.sv
// ============================================================================
// Module   : tb_mdom_wvb_hdr_writer
// Brief    : Directed-vector bench with a header scoreboard for the writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdom_wvb_hdr_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         trig;
  logic [48:0]  trig_ltc;
  logic [10:0]  trig_addr;
  logic [1:0]   trig_src_in;
  logic         cnst_run_in;
  logic [4:0]   pre_conf_in;
  logic         sync_rdy_in;
  logic [18:0]  bsum_in;
  logic [2:0]   bsum_len_sel_in;
  logic         bsum_valid_in;
  logic         evt_done;
  logic [10:0]  done_addr;
  logic [102:0] hdr_bundle;
  logic         hdr_wr;
  logic         hdr_full;
  logic         busy;
  logic         ovfl;
  logic         ovfl_clr;
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [102:0] exp_q[$];

  always #5 clk = ~clk;

  mdom_wvb_hdr_writer dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .trig_ltc(trig_ltc),
    .trig_addr(trig_addr), .trig_src_in(trig_src_in), .cnst_run_in(cnst_run_in),
    .pre_conf_in(pre_conf_in), .sync_rdy_in(sync_rdy_in), .bsum_in(bsum_in),
    .bsum_len_sel_in(bsum_len_sel_in), .bsum_valid_in(bsum_valid_in),
    .evt_done(evt_done), .done_addr(done_addr), .hdr_bundle(hdr_bundle),
    .hdr_wr(hdr_wr), .hdr_full(hdr_full), .busy(busy), .ovfl(ovfl),
    .ovfl_clr(ovfl_clr)
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  function automatic logic [102:0] pack(input logic [48:0] l, input logic [10:0] sa,
      input logic [10:0] sp, input logic [1:0] src, input logic cr, input logic [4:0] pc,
      input logic sr, input logic [18:0] bs, input logic [2:0] ls, input logic bv);
    return {bv, ls, bs, sr, pc, cr, src, sp, sa, l};
  endfunction

  task automatic check(input string name, input logic [102:0] act, input logic [102:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_fields(input logic [48:0] l, input logic [10:0] a, input logic [1:0] src,
      input logic cr, input logic [4:0] pc, input logic sr, input logic [18:0] bs,
      input logic [2:0] ls, input logic bv);
    trig_ltc = l; trig_addr = a; trig_src_in = src; cnst_run_in = cr;
    pre_conf_in = pc; sync_rdy_in = sr; bsum_in = bs; bsum_len_sel_in = ls;
    bsum_valid_in = bv;
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected header.
  always @(negedge clk) begin
    if (rst_n && hdr_wr) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wr: got header %0h with nothing expected", hdr_bundle);
      end else begin
        logic [102:0] e;
        e = exp_q.pop_front();
        if (hdr_bundle !== e) begin
          n_fail++;
          $display("FAIL hdr_content: got %0h expected %0h", hdr_bundle, e);
        end
      end
    end
  end

  initial begin
    int bad;
    rst_n = 1'b0; trig = 1'b0; evt_done = 1'b0; done_addr = '0;
    hdr_full = 1'b0; ovfl_clr = 1'b0;
    set_fields('0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hdr", hdr_bundle, '0);
    check("rst_wr", 103'(hdr_wr), '0);
    check("rst_busy", 103'(busy), '0);
    check("rst_ovfl", 103'(ovfl), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // Basic event, expected header hand-packed
    set_fields(49'h1_2345_6789_ABCD, 11'h010, 2'd2, 1'b0, 5'd8, 1'b1, 19'h4_0000, 3'd0, 1'b1);
    trig = 1'b1;
    exp_q.push_back(103'h44_0000_A10F_F021_2345_6789_ABCD);
    step(1); trig = 1'b0;
    @(negedge clk);
    check("busy_acq", 103'(busy), 103'd1);
    step(19);
    evt_done = 1'b1; done_addr = 11'h0FF;
    step(1); evt_done = 1'b0;
    @(negedge clk);
    check("lat_basic", 103'(hdr_wr), 103'd1);
    step(1);
    @(negedge clk);
    check("busy_idle", 103'(busy), '0);

    // Lone evt_done in IDLE is ignored
    evt_done = 1'b1; step(1); evt_done = 1'b0;
    @(negedge clk);
    check("done_idle_ignored", 103'(busy), '0);

    // Backpressure: 50 cycles of hdr_full in WRITE
    set_fields(49'h0_0000_0000_0042, 11'h100, 2'd1, 1'b1, 5'd3, 1'b0, 19'h1_2345, 3'd5, 1'b0);
    exp_q.push_back(pack(49'h0_0000_0000_0042, 11'h100, 11'h1A0, 2'd1, 1'b1, 5'd3, 1'b0,
                         19'h1_2345, 3'd5, 1'b0));
    hdr_full = 1'b1; trig = 1'b1;
    step(1); trig = 1'b0;
    step(3);
    evt_done = 1'b1; done_addr = 11'h1A0;
    step(1); evt_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hdr_wr !== 1'b0 || hdr_bundle !== exp_q[0] || busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold", 103'(bad), '0);
    hdr_full = 1'b0;
    @(negedge clk);
    check("bp_release", 103'(hdr_wr), 103'd1);
    step(1);

    // Overlapping trigger during ACQ
    set_fields(49'h0_ABCD_0000_1111, 11'h200, 2'd3, 1'b0, 5'd31, 1'b1, 19'h7_FFFF, 3'd7, 1'b1);
    exp_q.push_back(pack(49'h0_ABCD_0000_1111, 11'h200, 11'h055, 2'd3, 1'b0, 5'd31, 1'b1,
                         19'h7_FFFF, 3'd7, 1'b1));
    trig = 1'b1;
    step(1);
    set_fields(49'h1_FFFF_FFFF_FFFF, 11'h3AA, 2'd0, 1'b1, 5'd1, 1'b0, 19'h0_0001, 3'd1, 1'b0);
    step(1); trig = 1'b0;
    @(negedge clk);
    check("ovfl_set", 103'(ovfl), 103'd1);
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
    check("drop_cnt_1", 103'(drop_cnt), 103'd1);
`endif
    evt_done = 1'b1; done_addr = 11'h055;
    step(1); evt_done = 1'b0;
    step(1);
    ovfl_clr = 1'b1; step(1); ovfl_clr = 1'b0;
    @(negedge clk);
    check("ovfl_clr", 103'(ovfl), '0);
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
    check("drop_cnt_clr", 103'(drop_cnt), '0);
`endif

    // Clear and drop in the same cycle: set wins
    set_fields(49'h0_0000_1234_5678, 11'h001, 2'd0, 1'b0, 5'd0, 1'b0, 19'h0_0100, 3'd2, 1'b1);
    exp_q.push_back(pack(49'h0_0000_1234_5678, 11'h001, 11'h002, 2'd0, 1'b0, 5'd0, 1'b0,
                         19'h0_0100, 3'd2, 1'b1));
    trig = 1'b1;
    step(1);
    ovfl_clr = 1'b1;
    step(1); trig = 1'b0; ovfl_clr = 1'b0;
    @(negedge clk);
    check("ovfl_set_wins", 103'(ovfl), 103'd1);
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
    check("drop_cnt_set_wins", 103'(drop_cnt), 103'd1);
`endif
    evt_done = 1'b1; done_addr = 11'h002;
    step(1); evt_done = 1'b0;
    ovfl_clr = 1'b1; step(1); ovfl_clr = 1'b0;

    // Same-cycle trig and evt_done
    set_fields(49'h0_5555_AAAA_5555, 11'h7FE, 2'd1, 1'b1, 5'd16, 1'b1, 19'h2_AAAA, 3'd4, 1'b0);
    exp_q.push_back(pack(49'h0_5555_AAAA_5555, 11'h7FE, 11'h7FE, 2'd1, 1'b1, 5'd16, 1'b1,
                         19'h2_AAAA, 3'd4, 1'b0));
    trig = 1'b1; evt_done = 1'b1; done_addr = 11'h7FE;
    step(1); trig = 1'b0; evt_done = 1'b0;
    @(negedge clk);
    check("single_sample_wr", 103'(hdr_wr), 103'd1);
    step(1);

    // Reset while stalled in WRITE
    set_fields(49'h0_DEAD_BEEF_0000, 11'h123, 2'd2, 1'b0, 5'd4, 1'b1, 19'h0_0F0F, 3'd3, 1'b1);
    hdr_full = 1'b1; trig = 1'b1;
    step(1);
    step(1); trig = 1'b0;
    evt_done = 1'b1; done_addr = 11'h321;
    step(1); evt_done = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hdr", hdr_bundle, '0);
    check("midrst_busy", 103'(busy), '0);
    check("midrst_ovfl", 103'(ovfl), '0);
    check("midrst_wr", 103'(hdr_wr), '0);
    hdr_full = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_fields(49'h0_0000_0000_0001, 11'h0AB, 2'd3, 1'b1, 5'd2, 1'b0, 19'h0_0003, 3'd6, 1'b1);
    exp_q.push_back(pack(49'h0_0000_0000_0001, 11'h0AB, 11'h0CD, 2'd3, 1'b1, 5'd2, 1'b0,
                         19'h0_0003, 3'd6, 1'b1));
    trig = 1'b1;
    step(1); trig = 1'b0;
    @(negedge clk);
    check("first_trig_after_rst", 103'(busy), 103'd1);
    evt_done = 1'b1; done_addr = 11'h0CD;
    step(1); evt_done = 1'b0;
    step(1);

    // Address wrap plus a long run of drops
    set_fields(49'h0_7777_0000_7777, 11'h7F0, 2'd0, 1'b0, 5'd9, 1'b1, 19'h5_0505, 3'd0, 1'b0);
    exp_q.push_back(pack(49'h0_7777_0000_7777, 11'h7F0, 11'h00F, 2'd0, 1'b0, 5'd9, 1'b1,
                         19'h5_0505, 3'd0, 1'b0));
    trig = 1'b1;
    step(1);
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
    step(70000);
`else
    step(20);
`endif
    trig = 1'b0;
    @(negedge clk);
    check("ovfl_after_drops", 103'(ovfl), 103'd1);
`ifdef MDOM_WVB_HDR_DROP_CNT_EN
    check("drop_cnt_sat", 103'(drop_cnt), 103'hFFFF);
`endif
    evt_done = 1'b1; done_addr = 11'h00F;
    step(1); evt_done = 1'b0;
    step(1);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", 103'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
